chart_header_server: RTL
========================

Name: chart_header_server

Overview:
- Responder side of the menu's chart-lookup interface: the page drives `read_chart_id` and receives `chart_data` one `prog_clk` later.
- After reset, sequentially preloads every chart's name header from a byte-wide synchronous chart ROM into an on-chip register cache.
- Once loaded, serves any id with fixed 1-cycle latency, independent of ROM timing.
- Sits between the menu/play pages and the chart ROM.

Parameters:
- NUM_CHARTS, 6, number of chart ids served (ids 0..NUM_CHARTS-1).
- NAME_LEN, `NAME_LEN, characters per chart name.
- HDR_STRIDE, 16, ROM bytes between consecutive chart headers (≥ NAME_LEN).
- ROM_AW, 10, ROM byte-address width.

Ports:
- prog_clk  in  1  program clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- read_chart_id  in  8  (byte) requested chart id.
- chart_data  out  Chart  response for the id sampled on the previous edge.
- ready  out  1  1 = cache loaded, responses valid.
- rom_addr  out  ROM_AW  ROM byte address.
- rom_data  in  8  ROM byte for the address registered on the previous edge (1-cycle synchronous ROM).

Behaviour:
- One clock (`prog_clk`); reset synchronous, active-low (`rst`=0 at an edge resets).
- Reset values:
  - state=LOAD, ready=0, rom_addr=0.
  - Load counters=0.
  - All cache entries = NAME_LEN spaces (0x20).
  - chart_data: info.name = all spaces; all other Chart fields 0.
- This block drives only info.name; all other Chart fields are constant 0.
- FSM states: LOAD, DRAIN, SERVE.
- LOAD:
  - Issues one ROM address per cycle: rom_addr = id*HDR_STRIDE + k, for id 0..NUM_CHARTS-1 (outer) and k 0..NAME_LEN-1 (inner).
  - Address arithmetic is done at ROM_AW+4 bits and truncated to ROM_AW.
  - A delayed copy of (id,k) plus a valid bit tracks the byte returning next cycle; the returned byte is written to cache[id][k].
  - After the last address is issued → DRAIN.
- DRAIN: captures the final byte (one cycle) → SERVE, and ready rises on that same edge.
- Total load time is NUM_CHARTS*NAME_LEN+1 cycles after reset release: 6*NAME_LEN+1 with defaults.
- Character mapping on cache write:
  - 0x00 → 0x20.
  - Any byte <0x20 or >0x7E → '?' (0x3F).
  - Otherwise unchanged.
- Name packing: character k occupies info.name bits [8*(NAME_LEN-k)-1 -: 8], so character 0 is leftmost.
- SERVE:
  - Each edge registers chart_data.info.name <= cache[read_chart_id], giving exactly 1-cycle latency.
  - The id may change every cycle; a back-to-back sweep returns the previous cycle's id each cycle.
  - read_chart_id ≥ NUM_CHARTS → all spaces.
  - rom_addr holds its last value; the ROM is not accessed in SERVE.
- During LOAD/DRAIN:
  - chart_data.info.name = all spaces regardless of read_chart_id.
  - ready=0.
  - Partially loaded entries are never exposed.
- Reset asserted mid-load or in SERVE: restarts LOAD from id 0, k 0 on the next edge with reset deasserted. The cache is cleared to spaces and ready=0 on the reset edge.
- No reload without reset; the cache is read-only after load.
- Id 0 (free play) is loaded like any other id; consumers decide whether to display it.

Test Plan:
1. ROM holds id1 name "SONG A" padded with 0x00. Release rst and count cycles → ready=1 exactly NUM_CHARTS*NAME_LEN+1 cycles later; rom_addr sweeps 0..NAME_LEN-1, 16.., up to 5*16+NAME_LEN-1.
2. After ready, drive read_chart_id=1 at edge n → at edge n+1, info.name = "SONG A" followed by spaces; other Chart fields 0.
3. Sweep read_chart_id 0,1,2,3,4,5 on consecutive cycles → chart_data shows names for 0..5 one cycle behind; read_chart_id=6 and 255 → all spaces.
4. ROM byte 0x07 at id2 k0 and 0x7F at id2 k1 → name starts "??"; a 0x00 byte → space.
5. Assert rst for one cycle midway through load (cycle 20) → ready=0, rom_addr=0 next; full load completes NUM_CHARTS*NAME_LEN+1 cycles after release; no stale data.
6. Query read_chart_id=3 during LOAD → all spaces and ready=0 on every cycle until ready rises, then correct name one cycle after the next sample.

Source files
------------

// File: rtl/chart_header_server.sv
// Chart-lookup responder: preloads every chart's name header from a byte-wide
// synchronous ROM into a register cache, then answers any id with 1-cycle latency.
`ifndef NAME_LEN
`define NAME_LEN 12
`endif

package chart_pkg;
    localparam int CHART_NAME_LEN = `NAME_LEN;

    typedef struct packed {
        logic [8*CHART_NAME_LEN-1:0] name;
        logic [7:0]                  level;
    } chart_info_t;

    typedef struct packed {
        chart_info_t info;
        logic [15:0] note_count;
    } Chart;
endpackage

module chart_header_server
    import chart_pkg::*;
#(
    parameter int NUM_CHARTS = 6,
    parameter int NAME_LEN   = `NAME_LEN,
    parameter int HDR_STRIDE = 16,
    parameter int ROM_AW     = 10
) (
    input  logic              prog_clk,
    input  logic              rst,
    input  logic [7:0]        read_chart_id,
    output Chart              chart_data,
    output logic              ready,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data
);
    localparam int IDW = (NUM_CHARTS > 1) ? $clog2(NUM_CHARTS) : 1;
    localparam int KW  = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1;
    localparam int AW4 = ROM_AW + 4;
    localparam logic [IDW-1:0]        ID_LAST = IDW'(NUM_CHARTS - 1);
    localparam logic [KW-1:0]         K_LAST  = KW'(NAME_LEN - 1);
    localparam logic [8*NAME_LEN-1:0] SPACES  = {NAME_LEN{8'h20}};

    typedef enum logic [1:0] {LOAD, DRAIN, SERVE} state_t;

    state_t               state, state_next;
    logic [IDW-1:0]       ld_id, wr_id;
    logic [KW-1:0]        ld_k, wr_k;
    logic                 wr_valid;
    logic                 last_issue;
    logic [7:0]           cache [NUM_CHARTS][NAME_LEN];
    logic [8*NAME_LEN-1:0] name_q, rd_name;
    logic [AW4-1:0]       addr_full;

    // Non-printable bytes become '?', NUL padding becomes a space.
    function automatic logic [7:0] map_char(input logic [7:0] b);
        logic [7:0] c;
        c = b;
        if (b == 8'h00)
            c = 8'h20;
        else if (b < 8'h20 || b > 8'h7E)
            c = 8'h3F;
        return c;
    endfunction

    assign last_issue = (ld_id == ID_LAST) && (ld_k == K_LAST);

    // NOTE: state and datapath registers use <= so every flop samples pre-edge values.
    always_ff @(posedge prog_clk) begin
        if (!rst)
            state <= LOAD;
        else
            state <= state_next;
    end

    // NOTE: defaulting state_next first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (last_issue) state_next = DRAIN;
            DRAIN:   state_next = SERVE;
            SERVE:   state_next = SERVE;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        ready      = (state == SERVE);
        addr_full  = AW4'(ld_id) * AW4'(HDR_STRIDE) + AW4'(ld_k);
        rom_addr   = addr_full[ROM_AW-1:0];
        chart_data = '0;
        chart_data.info.name = name_q;
    end

    // Entries are only exposed in SERVE, after every byte has been written.
    always_comb begin
        rd_name = SPACES;
        if (state == SERVE && read_chart_id < 8'(NUM_CHARTS)) begin
            for (int k = 0; k < NAME_LEN; k++)
                rd_name[8*(NAME_LEN-k)-1 -: 8] = cache[read_chart_id[IDW-1:0]][k];
        end
    end

    // NOTE: the cache is reset explicitly because unloaded entries must read as spaces, not X.
    always_ff @(posedge prog_clk) begin
        if (!rst) begin
            ld_id    <= '0;
            ld_k     <= '0;
            wr_id    <= '0;
            wr_k     <= '0;
            wr_valid <= 1'b0;
            name_q   <= SPACES;
            for (int i = 0; i < NUM_CHARTS; i++)
                for (int k = 0; k < NAME_LEN; k++)
                    cache[i][k] <= 8'h20;
        end else begin
            wr_valid <= (state == LOAD);
            wr_id    <= ld_id;
            wr_k     <= ld_k;
            if (state == LOAD && !last_issue) begin
                if (ld_k == K_LAST) begin
                    ld_k  <= '0;
                    ld_id <= ld_id + 1'b1;
                end else begin
                    ld_k <= ld_k + 1'b1;
                end
            end
            if (wr_valid)
                cache[wr_id][wr_k] <= map_char(rom_data);
            name_q <= rd_name;
        end
    end
endmodule
